// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD GPIO readback path: field positions of the
// request/result words, the readback FSM states and the averaging limit.
package spgd_pkg;

    // Largest averaging exponent; accumulators are sized from it.
    localparam int MAX_LOG2_AVG = 10;

    // Request word (PS -> fabric).
    localparam int GP_IN_REQ_BIT = 31;
    localparam int GP_IN_K_MSB   = 3;
    localparam int GP_IN_K_LSB   = 0;

    // Result word (fabric -> PS).
    localparam int GP_OUT_ACK_BIT  = 31;
    localparam int GP_OUT_BUSY_BIT = 30;
    localparam int GP_OUT_B_MSB    = 27;
    localparam int GP_OUT_B_LSB    = 14;
    localparam int GP_OUT_A_MSB    = 13;
    localparam int GP_OUT_A_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    // Exponents above the supported maximum are treated as the maximum.
    function automatic logic [3:0] clamp_log2_avg(input logic [3:0] k);
        return (k > 4'(MAX_LOG2_AVG)) ? 4'(MAX_LOG2_AVG) : k;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for bits arriving from the PS GPIO bus, which is
// asynchronous to the local clock. Shared with the DAC generator's GP_IN path.
module gpio_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/spgd_adc_readback.sv
// ADC readback for the SPGD loop: on a toggled request from the PS, average
// 2^k samples of both ADC channels and return them on GP_OUT with a toggle ACK.
module spgd_adc_readback
    import spgd_pkg::*;
#(
    parameter int GPIO_WIDTH = 32,
    parameter int ADC_WIDTH  = 14
) (
    input  logic                  ADC_CLK,
    input  logic                  RST,
    input  logic [GPIO_WIDTH-1:0] GP_IN,
    input  logic [ADC_WIDTH-1:0]  ADC_A_IN,
    input  logic [ADC_WIDTH-1:0]  ADC_B_IN,
    output logic [GPIO_WIDTH-1:0] GP_OUT
);

    // Wide enough for 2^MAX_LOG2_AVG full-scale negative samples.
    localparam int ACC_W = ADC_WIDTH + MAX_LOG2_AVG;
    localparam int EXT_W = ACC_W - ADC_WIDTH;
    localparam int CNT_W = MAX_LOG2_AVG + 1;

    state_t                  state_reg, state_next;
    logic                    req_s;
    logic                    req_acc_reg, req_acc_next;
    logic                    ack_reg, ack_next;
    logic                    busy_reg, busy_next;
    logic [3:0]              k_reg, k_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next, cnt_last;
    logic signed [ACC_W-1:0] acc_a_reg, acc_a_next;
    logic signed [ACC_W-1:0] acc_b_reg, acc_b_next;
    logic signed [ACC_W-1:0] samp_a_ext, samp_b_ext;
    logic [ADC_WIDTH-1:0]    avg_a_reg, avg_a_next;
    logic [ADC_WIDTH-1:0]    avg_b_reg, avg_b_next;
    logic                    unused_gp_in;

    gpio_sync #(.WIDTH(1)) u_req_sync (
        .clk  (ADC_CLK),
        .srst (RST),
        .d    (GP_IN[GP_IN_REQ_BIT]),
        .q    (req_s)
    );

    // Only REQ and k carry meaning in the request word.
    assign unused_gp_in = ^GP_IN[GP_IN_REQ_BIT-1:GP_IN_K_MSB+1];

    assign samp_a_ext = {{EXT_W{ADC_A_IN[ADC_WIDTH-1]}}, ADC_A_IN};
    assign samp_b_ext = {{EXT_W{ADC_B_IN[ADC_WIDTH-1]}}, ADC_B_IN};
    // Index of the last sample of the window, N-1.
    assign cnt_last   = (CNT_W'(1) << k_reg) - CNT_W'(1);

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge ADC_CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            req_acc_reg <= 1'b0;
            ack_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            k_reg       <= '0;
            cnt_reg     <= '0;
            acc_a_reg   <= '0;
            acc_b_reg   <= '0;
            avg_a_reg   <= '0;
            avg_b_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            req_acc_reg <= req_acc_next;
            ack_reg     <= ack_next;
            busy_reg    <= busy_next;
            k_reg       <= k_next;
            cnt_reg     <= cnt_next;
            acc_a_reg   <= acc_a_next;
            acc_b_reg   <= acc_b_next;
            avg_a_reg   <= avg_a_next;
            avg_b_reg   <= avg_b_next;
        end
    end

    // Next-state logic: accept on REQ_S != ACK, accumulate N samples, publish.
    always_comb begin
        state_next   = state_reg;
        req_acc_next = req_acc_reg;
        ack_next     = ack_reg;
        busy_next    = busy_reg;
        k_next       = k_reg;
        cnt_next     = cnt_reg;
        acc_a_next   = acc_a_reg;
        acc_b_next   = acc_b_reg;
        avg_a_next   = avg_a_reg;
        avg_b_next   = avg_b_reg;
        case (state_reg)
            IDLE: begin
                if (req_s != ack_reg) begin
                    req_acc_next = req_s;
                    k_next       = clamp_log2_avg(GP_IN[GP_IN_K_MSB:GP_IN_K_LSB]);
                    cnt_next     = '0;
                    acc_a_next   = '0;
                    acc_b_next   = '0;
                    busy_next    = 1'b1;
                    state_next   = ACCUM;
                end
            end
            ACCUM: begin
                acc_a_next = acc_a_reg + samp_a_ext;
                acc_b_next = acc_b_reg + samp_b_ext;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == cnt_last) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: begin
                // Floor average always lies in the sample range, so truncation is exact.
                avg_a_next = ADC_WIDTH'(acc_a_reg >>> k_reg);
                avg_b_next = ADC_WIDTH'(acc_b_reg >>> k_reg);
                ack_next   = req_acc_reg;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result word assembly; every field comes straight from a register.
    always_comb begin
        GP_OUT                              = '0;
        GP_OUT[GP_OUT_ACK_BIT]              = ack_reg;
        GP_OUT[GP_OUT_BUSY_BIT]             = busy_reg;
        GP_OUT[GP_OUT_B_MSB:GP_OUT_B_LSB]   = avg_b_reg;
        GP_OUT[GP_OUT_A_MSB:GP_OUT_A_LSB]   = avg_a_reg;
    end

endmodule

// File: tb/tb_spgd_adc_readback.sv
// Bench for spgd_adc_readback: drives toggle requests and sample streams,
// predicts each published word and its edge, and checks them as they appear.
module tb_spgd_adc_readback;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gp_in;
    logic [13:0] adc_a;
    logic [13:0] adc_b;
    logic [31:0] gp_out;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          edge_cnt = 0;
    logic        req_lvl  = 1'b0;
    logic [27:0] last_fields = '0;

    typedef struct {
        logic [31:0] word;
        int          edge_n;
    } exp_t;

    exp_t sb_q[$];

    spgd_adc_readback dut (
        .ADC_CLK  (clk),
        .RST      (rst),
        .GP_IN    (gp_in),
        .ADC_A_IN (adc_a),
        .ADC_B_IN (adc_b),
        .GP_OUT   (gp_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] make_word(input logic ack, input int sum_a, input int sum_b, input int kc);
        logic [31:0] ua;
        logic [31:0] ub;
        ua = sum_a >>> kc;
        ub = sum_b >>> kc;
        return {ack, 1'b0, 2'b00, ub[13:0], ua[13:0]};
    endfunction

    task automatic check_busy(input string name, input int c, input int e0, input int n, input bit second);
        logic exp_b;
        exp_b = (c >= e0 + 2 && c <= e0 + n + 2) ||
                (second && c >= e0 + n + 4 && c <= e0 + 2 * n + 4);
        check_eq({name, "_busy"}, {31'd0, gp_out[30]}, {31'd0, exp_b});
    endtask

    // Publish monitor: every ACK change must match the head of the scoreboard.
    initial begin
        exp_t x;
        logic prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_ack = 1'b0;
            end else if (gp_out[31] != prev_ack) begin
                prev_ack = gp_out[31];
                $display("[TB] publish at edge %0d GP_OUT=%h", edge_cnt, gp_out);
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_publish", 32'd1, 32'd0);
                end else begin
                    x = sb_q.pop_front();
                    check_eq("publish_edge", edge_cnt, x.edge_n);
                    check_eq("publish_word", gp_out, x.word);
                end
            end
        end
    end

    // One request: optional REQ toggle, then drive samples edge by edge.
    // mode 0: A = a0 + a_step*(e - e3), B = b0; mode 1: random samples.
    // extra toggles land during ACCUM; an odd count implies a second transaction.
    task automatic run_txn(input string name, input bit toggle, input int k_field, input int extra,
                           input int mode, input int a0, input int a_step, input int b0);
        int kc, n, e0, last_e, c;
        int sum_a1, sum_b1, sum_a2, sum_b2;
        bit second;
        logic ack1;
        logic [13:0] a, b;
        logic signed [13:0] sa, sbv;
        exp_t x;
        sum_a1 = 0; sum_b1 = 0; sum_a2 = 0; sum_b2 = 0;
        kc = (k_field > 10) ? 10 : k_field;
        n = 1 << kc;
        second = (extra % 2) == 1;
        @(negedge clk);
        rst = 1'b0;
        if (toggle) req_lvl = ~req_lvl;
        gp_in = '0;
        gp_in[31] = req_lvl;
        gp_in[3:0] = 4'(k_field);
        ack1 = req_lvl;
        e0 = edge_cnt + 1;
        last_e = second ? e0 + 2 * n + 5 : e0 + n + 3;
        for (int e = e0; e <= last_e; e++) begin
            c = e - 1;
            check_busy(name, c, e0, n, second);
            if (c == e0 + 2 || (second && c == e0 + n + 4))
                check_eq({name, "_hold"}, {4'h0, gp_out[27:0]}, {4'h0, last_fields});
            if (extra > 0 && e >= e0 + 4 && e < e0 + 4 + 2 * extra && ((e - e0) % 2) == 0) begin
                req_lvl = ~req_lvl;
                gp_in[31] = req_lvl;
            end
            if (mode == 1) begin
                a = 14'($urandom);
                b = 14'($urandom);
            end else begin
                a = 14'(a0 + a_step * (e - e0 - 3));
                b = 14'(b0);
            end
            adc_a = a;
            adc_b = b;
            sa = a;
            sbv = b;
            if (e >= e0 + 3 && e <= e0 + n + 2) begin
                sum_a1 += sa;
                sum_b1 += sbv;
            end
            if (second && e >= e0 + n + 5 && e <= e0 + 2 * n + 4) begin
                sum_a2 += sa;
                sum_b2 += sbv;
            end
            if (e == e0 + n + 2) begin
                x.word = make_word(ack1, sum_a1, sum_b1, kc);
                x.edge_n = e0 + n + 3;
                sb_q.push_back(x);
                last_fields = x.word[27:0];
            end
            if (second && e == e0 + 2 * n + 4) begin
                x.word = make_word(req_lvl, sum_a2, sum_b2, kc);
                x.edge_n = e0 + 2 * n + 5;
                sb_q.push_back(x);
                last_fields = x.word[27:0];
            end
            @(negedge clk);
        end
        check_busy(name, last_e, e0, n, second);
    endtask

    initial begin
        int e0;
        rst = 1'b1;
        gp_in = '0;
        adc_a = '0;
        adc_b = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_gp_out", gp_out, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_no_req", gp_out, 32'h0);

        run_txn("const_k3",   1'b1, 3,  0, 0, 100,   0, -5);
        run_txn("ramp_k3",    1'b1, 3,  0, 0, 0,     1, -1);
        run_txn("min_k15",    1'b1, 15, 0, 0, -8192, 0, -8192);
        run_txn("rand_k0",    1'b1, 0,  0, 1, 0,     0, 0);
        run_txn("rand_k2",    1'b1, 2,  0, 1, 0,     0, 0);
        run_txn("dbl_toggle", 1'b1, 3,  2, 0, 1234,  3, -77);
        repeat (20) @(negedge clk);
        check_eq("dbl_idle_busy", {31'd0, gp_out[30]}, 32'd0);
        check_eq("dbl_no_pending", sb_q.size(), 32'd0);
        run_txn("tri_toggle", 1'b1, 3,  3, 0, -300,  5, 2000);

        // Reset in the middle of a k=5 accumulation with REQ left high.
        @(negedge clk);
        req_lvl = ~req_lvl;
        gp_in = '0;
        gp_in[31] = req_lvl;
        gp_in[3:0] = 4'd5;
        e0 = edge_cnt + 1;
        repeat (6) @(negedge clk);
        check_eq("pre_rst_busy", {31'd0, gp_out[30]}, 32'd1);
        check_eq("pre_rst_edge", edge_cnt, e0 + 5);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_gp_out", gp_out, 32'h0);
        last_fields = '0;
        run_txn("after_rst",  1'b0, 5,  0, 0, 500,  -7, -4000);

        repeat (5) @(negedge clk);
        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
